// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD maximum tracker.
// Holds the digit geometry, the tracker FSM state type and a helper that
// flags any 4-digit BCD word containing a non-decimal digit.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DATA_W     = DIGIT_W * NUM_DIGITS;
  localparam logic [DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_UPD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True when any digit of the word lies outside 0..9.
  function automatic logic has_bad_digit(input logic [DATA_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] > BCD_DIGIT_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// Single-digit magnitude comparator.
// Ports:
//   a_digit, b_digit : 4-bit digits to compare (a = candidate, b = reference)
//   gt / lt / eq     : a > b, a < b, a == b (exactly one is high)
module bcd_digit_cmp
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_digit,
  input  logic [DIGIT_W-1:0] b_digit,
  output logic               gt,
  output logic               lt,
  output logic               eq
);

  assign gt = (a_digit >  b_digit);
  assign lt = (a_digit <  b_digit);
  assign eq = (a_digit == b_digit);

endmodule

// File: rtl/bcd_max_tracker.sv
// Tracks the largest 4-digit BCD sample seen since reset or clear.
// A sample is compared against the stored maximum one digit per cycle,
// most significant digit first, using one shared digit comparator.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous clear of all tracker contents
//   in_valid, in_data   : sample offer (4-digit BCD), in_ready handshake
//   max_val, max_valid  : current maximum and whether it holds a sample
//   sample_cnt          : saturating count of accepted valid samples
//   done, new_max       : end-of-processing pulse, qualified by replacement
//   bad_bcd             : pulse after an accepted sample with a digit > 9
module bcd_max_tracker
  import bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] max_val,
  output logic              max_valid,
  output logic [7:0]        sample_cnt,
  output logic              done,
  output logic              new_max,
  output logic              bad_bcd
);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] smp_q, smp_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic              max_valid_q, max_valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              updated_q, updated_d;
  logic              done_q, done_d;
  logic              new_max_q, new_max_d;
  logic              bad_bcd_q, bad_bcd_d;

  logic [DIGIT_W-1:0] smp_digit, max_digit;
  logic               dig_gt, dig_lt, dig_eq;
  logic               accept;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // The digit index selects the same position in both words so one
  // comparator serves all four digits over successive cycles.
  assign smp_digit = smp_q[{idx_q, 2'b00} +: DIGIT_W];
  assign max_digit = max_val_q[{idx_q, 2'b00} +: DIGIT_W];

  bcd_digit_cmp u_digit_cmp (
    .a_digit (smp_digit),
    .b_digit (max_digit),
    .gt      (dig_gt),
    .lt      (dig_lt),
    .eq      (dig_eq)
  );

  assign in_ready = (state_q == ST_IDLE) && !clear && rst_n;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    smp_d       = smp_q;
    max_val_d   = max_val_q;
    max_valid_d = max_valid_q;
    cnt_d       = cnt_q;
    updated_d   = updated_q;
    bad_bcd_d   = 1'b0;

    if (clear) begin
      // Clear wins over any in-flight compare; nothing is reported for it.
      state_d     = ST_IDLE;
      idx_d       = 2'd3;
      max_val_d   = '0;
      max_valid_d = 1'b0;
      cnt_d       = '0;
      updated_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (has_bad_digit(in_data)) begin
              bad_bcd_d = 1'b1;
            end else begin
              smp_d     = in_data;
              cnt_d     = sat_inc(cnt_q);
              updated_d = 1'b0;
              idx_d     = 2'd3;
              state_d   = max_valid_q ? ST_CMP : ST_UPD;
            end
          end
        end
        ST_CMP: begin
          if (dig_gt) begin
            state_d = ST_UPD;
          end else if (dig_lt || (dig_eq && idx_q == 2'd0)) begin
            // Lower digit or a complete tie: keep the stored maximum.
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end
        ST_UPD: begin
          max_val_d   = smp_q;
          max_valid_d = 1'b1;
          updated_d   = 1'b1;
          state_d     = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    done_d    = (state_d == ST_DONE);
    new_max_d = done_d && updated_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd3;
      smp_q       <= '0;
      max_val_q   <= '0;
      max_valid_q <= 1'b0;
      cnt_q       <= '0;
      updated_q   <= 1'b0;
      done_q      <= 1'b0;
      new_max_q   <= 1'b0;
      bad_bcd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      smp_q       <= smp_d;
      max_val_q   <= max_val_d;
      max_valid_q <= max_valid_d;
      cnt_q       <= cnt_d;
      updated_q   <= updated_d;
      done_q      <= done_d;
      new_max_q   <= new_max_d;
      bad_bcd_q   <= bad_bcd_d;
    end
  end

  assign max_val    = max_val_q;
  assign max_valid  = max_valid_q;
  assign sample_cnt = cnt_q;
  assign done       = done_q;
  assign new_max    = new_max_q;
  assign bad_bcd    = bad_bcd_q;

endmodule

// File: tb/tb_bcd_max_tracker.sv
// Directed bench for bcd_max_tracker: reset state, first sample, per-digit
// compare latencies, ties, bad BCD, clear/reset aborts and a long stream.
module tb_bcd_max_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic [15:0] max_val;
  logic        max_valid;
  logic [7:0]  sample_cnt;
  logic        done;
  logic        new_max;
  logic        bad_bcd;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bcd_max_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .max_val    (max_val),
    .max_valid  (max_valid),
    .sample_cnt (sample_cnt),
    .done       (done),
    .new_max    (new_max),
    .bad_bcd    (bad_bcd)
  );

  // Offer one sample; returns at the falling edge after the accept edge,
  // with in_valid dropped and in_data scrambled.
  task automatic send(input logic [15:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h9999;
  endtask

  // Counts falling edges from the one after the accept edge (=1) until done.
  task automatic wait_done(output int lat, output logic nm, output bit spur);
    lat  = 1;
    nm   = 1'b0;
    spur = 1'b0;
    while (done !== 1'b1 && lat < 12) begin
      if (new_max !== 1'b0) spur = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = 99;
    else nm = new_max;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    repeat (2) @(negedge clk);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (max_val !== 16'h0000) $display("FAIL rst_max_val got %h want 0000", max_val); else pass_cnt++;
    total_cnt++; if (max_valid !== 1'b0) $display("FAIL rst_max_valid got %b want 0", max_valid); else pass_cnt++;
    total_cnt++; if (sample_cnt !== 8'd0) $display("FAIL rst_cnt got %0d want 0", sample_cnt); else pass_cnt++;
    total_cnt++; if ({done, new_max, bad_bcd} !== 3'b000) $display("FAIL rst_pulses got %b want 000", {done, new_max, bad_bcd}); else pass_cnt++;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_first();
    bit ok, spur; int lat; logic nm;
    send(16'h1234, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 2) $display("FAIL first_lat got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (nm !== 1'b1 || spur) $display("FAIL first_new_max got %b spur %b want 1/0", nm, spur); else pass_cnt++;
    total_cnt++; if (max_val !== 16'h1234) $display("FAIL first_max got %h want 1234", max_val); else pass_cnt++;
    total_cnt++; if (sample_cnt !== 8'd1 || max_valid !== 1'b1) $display("FAIL first_cnt got %0d/%b want 1/1", sample_cnt, max_valid); else pass_cnt++;
  endtask

  task automatic test_msd();
    bit ok, spur; int lat; logic nm;
    send(16'h2000, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 3 || nm !== 1'b1) $display("FAIL gt_msd got lat %0d nm %b want 3/1", lat, nm); else pass_cnt++;
    send(16'h1999, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 2 || nm !== 1'b0 || spur) $display("FAIL lt_msd got lat %0d nm %b want 2/0", lat, nm); else pass_cnt++;
    total_cnt++; if (max_val !== 16'h2000) $display("FAIL lt_msd_max got %h want 2000", max_val); else pass_cnt++;
  endtask

  task automatic test_lsd_and_tie();
    bit ok, spur; int lat; logic nm;
    send(16'h5678, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 3 || nm !== 1'b1) $display("FAIL load_5678 got lat %0d nm %b want 3/1", lat, nm); else pass_cnt++;
    send(16'h5679, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 6 || nm !== 1'b1) $display("FAIL gt_lsd got lat %0d nm %b want 6/1", lat, nm); else pass_cnt++;
    send(16'h5679, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 5 || nm !== 1'b0 || spur) $display("FAIL tie got lat %0d nm %b want 5/0", lat, nm); else pass_cnt++;
    send(16'h5669, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 4 || nm !== 1'b0) $display("FAIL lt_d1 got lat %0d nm %b want 4/0", lat, nm); else pass_cnt++;
    total_cnt++; if (max_val !== 16'h5679 || sample_cnt !== 8'd7) $display("FAIL after_tie got %h/%0d want 5679/7", max_val, sample_cnt); else pass_cnt++;
  endtask

  task automatic test_bad_bcd();
    bit ok, saw_done;
    send(16'h12A4, ok);
    total_cnt++; if (bad_bcd !== 1'b1) $display("FAIL bad_pulse got %b want 1", bad_bcd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bad_bcd !== 1'b0) $display("FAIL bad_pulse_len got %b want 0", bad_bcd); else pass_cnt++;
    saw_done = 1'b0;
    repeat (6) begin
      if (done !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (saw_done) $display("FAIL bad_done got 1 want 0"); else pass_cnt++;
    total_cnt++; if (sample_cnt !== 8'd7 || max_val !== 16'h5679) $display("FAIL bad_state got %0d/%h want 7/5679", sample_cnt, max_val); else pass_cnt++;
  endtask

  task automatic test_clear();
    bit ok, spur, saw_done; int lat; logic nm;
    send(16'h5680, ok);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      if (done !== 1'b0 || new_max !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (saw_done) $display("FAIL clr_done got 1 want 0"); else pass_cnt++;
    total_cnt++; if ({max_valid, sample_cnt, max_val} !== 25'd0) $display("FAIL clr_state got %b/%0d/%h want 0/0/0000", max_valid, sample_cnt, max_val); else pass_cnt++;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL clr_ready got %b want 0", in_ready); else pass_cnt++;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    total_cnt++; if (sample_cnt !== 8'd0) $display("FAIL clr_no_accept got %0d want 0", sample_cnt); else pass_cnt++;
    send(16'h0042, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 2 || nm !== 1'b1 || sample_cnt !== 8'd1) $display("FAIL clr_first got lat %0d nm %b cnt %0d want 2/1/1", lat, nm, sample_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_upd();
    bit ok, spur, saw_done; int lat; logic nm;
    send(16'h0500, ok);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({done, max_valid, sample_cnt, in_ready} !== 11'd0) $display("FAIL rstu_state got %b/%b/%0d/%b want all 0", done, max_valid, sample_cnt, in_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      if (done !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    total_cnt++; if (saw_done || max_val !== 16'h0000) $display("FAIL rstu_abort got done %b max %h want 0/0000", saw_done, max_val); else pass_cnt++;
    send(16'h0007, ok);
    wait_done(lat, nm, spur);
    total_cnt++; if (lat !== 2 || nm !== 1'b1 || max_val !== 16'h0007) $display("FAIL rstu_first got lat %0d nm %b max %h want 2/1/0007", lat, nm, max_val); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[300];
    logic [15:0] ref_max;
    int ref_dec, dec, acc, cyc;
    ref_dec = -1;
    ref_max = 16'h0000;
    for (int i = 0; i < 300; i++) begin
      int d3, d2, d1, d0;
      d3 = $urandom_range(0, 9); d2 = $urandom_range(0, 9);
      d1 = $urandom_range(0, 9); d0 = $urandom_range(0, 9);
      vals[i] = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
      dec = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
      if (dec > ref_dec) begin
        ref_dec = dec;
        ref_max = vals[i];
      end
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    acc      = 0;
    cyc      = 0;
    in_valid = 1'b1;
    in_data  = vals[0];
    while (acc < 300 && cyc < 5000) begin
      if (in_ready) begin
        @(posedge clk);
        acc++;
        @(negedge clk);
        if (acc < 300) in_data = vals[acc];
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++; if (acc !== 300) $display("FAIL stream_accepts got %0d want 300", acc); else pass_cnt++;
    total_cnt++; if (sample_cnt !== 8'd255) $display("FAIL stream_sat got %0d want 255", sample_cnt); else pass_cnt++;
    total_cnt++; if (max_val !== ref_max || max_valid !== 1'b1) $display("FAIL stream_max got %h/%b want %h/1", max_val, max_valid, ref_max); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first();
    test_msd();
    test_lsd_and_tie();
    test_bad_bcd();
    test_clear();
    test_reset_upd();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
